// File: rtl/sync_ram_block.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram_block
// Purpose  : Simple dual-port synchronous RAM with a registered, read-first read port.
// Revision : 1.0
// ============================================================================
module sync_ram_block #(
  parameter int  WIDTH_P = 8,
  parameter int  DEPTH_P = 16,
  localparam int ADDR_W  = $clog2(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  output logic [WIDTH_P-1:0] data_o
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH_P);

  if (DEPTH_P < 2) begin : g_bad_depth
    $fatal(1, "sync_ram_block: DEPTH_P must be >= 2");
  end
  if (WIDTH_P < 1) begin : g_bad_width
    $fatal(1, "sync_ram_block: WIDTH_P must be >= 1");
  end

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [WIDTH_P-1:0] data_q;
  logic [WIDTH_P-1:0] data_d;
  logic               w_wr_in_range;
  logic               w_rd_in_range;

  // Addresses past the last word only exist when DEPTH_P is not a power of two.
  assign w_wr_in_range = ({1'b0, wr_addr_i} < C_DEPTH);
  assign w_rd_in_range = ({1'b0, rd_addr_i} < C_DEPTH);

  // No reset on the array so the tools can map it to block RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_i && w_wr_in_range) begin
      mem[wr_addr_i] <= data_i;
    end
  end

  always_comb begin
    data_d = data_q;
    if (rd_en_i) begin
      data_d = w_rd_in_range ? mem[rd_addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_ram_block
// Purpose  : Directed self-checking bench for sync_ram_block (16-deep and 12-deep instances).
// Revision : 1.0
// ============================================================================
module tb_sync_ram_block;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] dout;
  logic [7:0] dout12;

  int checks   = 0;
  int failures = 0;

  sync_ram_block #(.WIDTH_P(8), .DEPTH_P(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .data_i   (data_in),
    .wr_addr_i(wr_addr),
    .rd_addr_i(rd_addr),
    .wr_en_i  (wr_en),
    .rd_en_i  (rd_en),
    .data_o   (dout)
  );

  // Non-power-of-two depth: addresses 12..15 are out of range.
  sync_ram_block #(.WIDTH_P(8), .DEPTH_P(12)) dut12 (
    .clk_i    (clk),
    .rst_i    (rst),
    .data_i   (data_in),
    .wr_addr_i(wr_addr),
    .rd_addr_i(rd_addr),
    .wr_en_i  (wr_en),
    .rd_en_i  (rd_en),
    .data_o   (dout12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr_addr = a; data_in = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    data_in = '0; wr_addr = '0; rd_addr = '0;
    #3 rst = 1'b1;
    tick(); tick();
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL reset_dout16: got %h expected 00", dout);
    end
    checks++;
    if (dout12 !== 8'h00) begin
      failures++; $display("FAIL reset_dout12: got %h expected 00", dout12);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_write(4'd0, 8'd42);
    do_read(4'd0);
    checks++;
    if (dout !== 8'd42) begin
      failures++; $display("FAIL basic_read16: got %0d expected 42", dout);
    end
    checks++;
    if (dout12 !== 8'd42) begin
      failures++; $display("FAIL basic_read12: got %0d expected 42", dout12);
    end
  endtask

  task automatic test_top_addr();
    do_write(4'd15, 8'hFF);
    do_write(4'd11, 8'hFF);
    do_read(4'd15);
    checks++;
    if (dout !== 8'hFF) begin
      failures++; $display("FAIL top_addr16: got %h expected ff", dout);
    end
    do_read(4'd11);
    checks++;
    if (dout12 !== 8'hFF) begin
      failures++; $display("FAIL top_addr12: got %h expected ff", dout12);
    end
  endtask

  task automatic test_read_first();
    do_write(4'd0, 8'd7);
    wr_addr = 4'd0; rd_addr = 4'd0; data_in = 8'd13;
    wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (dout !== 8'd7) begin
      failures++; $display("FAIL read_first_old: got %0d expected 7", dout);
    end
    do_read(4'd0);
    checks++;
    if (dout !== 8'd13) begin
      failures++; $display("FAIL read_first_new: got %0d expected 13", dout);
    end
  endtask

  task automatic test_different_addr();
    do_write(4'd5, 8'h3C);
    wr_addr = 4'd6; rd_addr = 4'd5; data_in = 8'hC3;
    wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (dout !== 8'h3C) begin
      failures++; $display("FAIL diff_addr_read: got %h expected 3c", dout);
    end
    do_read(4'd6);
    checks++;
    if (dout !== 8'hC3) begin
      failures++; $display("FAIL diff_addr_write: got %h expected c3", dout);
    end
  endtask

  task automatic test_sequential();
    logic [7:0] vals [16];
    logic [7:0] exp12;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'($urandom_range(1, 255));
      do_write(4'(i), vals[i]);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      exp12 = (i < 12) ? vals[i] : 8'h00;
      checks++;
      if (dout !== vals[i]) begin
        failures++; $display("FAIL seq_read16[%0d]: got %h expected %h", i, dout, vals[i]);
      end
      checks++;
      if (dout12 !== exp12) begin
        failures++; $display("FAIL seq_read12[%0d]: got %h expected %h", i, dout12, exp12);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_write(4'd1, 8'h11);
    do_write(4'd13, 8'h5A);
    do_read(4'd1);
    checks++;
    if (dout12 !== 8'h11) begin
      failures++; $display("FAIL oor_setup12: got %h expected 11", dout12);
    end
    do_read(4'd13);
    checks++;
    if (dout12 !== 8'h00) begin
      failures++; $display("FAIL oor_read12: got %h expected 00", dout12);
    end
    checks++;
    if (dout !== 8'h5A) begin
      failures++; $display("FAIL oor_inrange16: got %h expected 5a", dout);
    end
  endtask

  task automatic test_hold_and_reset();
    do_write(4'd2, 8'hA5);
    do_read(4'd2);
    do_write(4'd3, 8'h01);
    do_write(4'd2, 8'h77);
    rd_addr = 4'd2;
    tick(); tick();
    checks++;
    if (dout !== 8'hA5) begin
      failures++; $display("FAIL hold_rd_en_low: got %h expected a5", dout);
    end
    // Assert reset between edges: the output must clear without waiting for a clock.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL async_reset_clear: got %h expected 00", dout);
    end
    wr_addr = 4'd2; data_in = 8'h99; wr_en = 1'b1;
    rd_addr = 4'd2; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL reset_held_read: got %h expected 00", dout);
    end
    rst = 1'b0;
    tick();
    do_read(4'd2);
    checks++;
    if (dout !== 8'h77) begin
      failures++; $display("FAIL write_ignored_in_reset: got %h expected 77", dout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_addr();
    test_read_first();
    test_different_addr();
    test_sequential();
    test_out_of_range();
    test_hold_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
